calc_port_arbiter: RTL and testbench
====================================

Name: calc_port_arbiter

Overview:
- Shares one calculator port (cmd/data request in, resp/data result out) between NUM_REQ independent requesters.
- Accepts one operation at a time via valid/ready, picks the next requester round-robin, and drives the two-cycle calculator request sequence: command with operand 1, then operand 2.
- Waits for the calculator's single-cycle response, guards the wait with a timeout, and routes the result back to the granted requester.
- Sits between the stimulus/requester side and one calculator port; one instance per port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, operand/result width
- RESP_WIDTH, 2, calculator response width
- CMD_WIDTH, 4, calculator command width
- TIMEOUT, 64, max cycles spent in WAIT_RESP before forcing an error response

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operation pending
- req_cmd  in  NUM_REQ*CMD_WIDTH  packed commands; requester i at bits [i*CMD_WIDTH +: CMD_WIDTH]
- req_op1  in  NUM_REQ*DATA_WIDTH  packed operand 1
- req_op2  in  NUM_REQ*DATA_WIDTH  packed operand 2
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  1  result pulse
- rsp_id  out  clog2(NUM_REQ)  requester index for the result
- rsp_resp  out  RESP_WIDTH  response code: 1 = ok, 2 = overflow/invalid, 3 = timeout
- rsp_data  out  DATA_WIDTH  result data
- calc_cmd_out  out  CMD_WIDTH  to calculator req_cmd_in
- calc_data_out  out  DATA_WIDTH  to calculator req_data_in
- calc_resp_in  in  RESP_WIDTH  from calculator out_resp
- calc_data_in  in  DATA_WIDTH  from calculator out_data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, any state): state = IDLE; rr_ptr = 0; all outputs 0; calc_cmd_out = 0 (no-op); timeout counter = 0.
- All outputs are registered.
- FSM states: IDLE, SEND_OP1, SEND_OP2, WAIT_RESP, RETURN.
- IDLE:
  - If any req_valid is high, select the first set bit searching from rr_ptr upward with wrap-around (rr_ptr itself has highest priority).
  - Pulse req_ready[sel] for 1 cycle, latch cmd/op1/op2 and sel, go to SEND_OP1.
  - The requester must hold its request stable until it sees ready; transfer occurs on ready.
- SEND_OP1: calc_cmd_out = latched cmd, calc_data_out = op1 for exactly 1 cycle -> SEND_OP2.
- SEND_OP2: calc_cmd_out = 0, calc_data_out = op2 for 1 cycle -> WAIT_RESP; timeout counter cleared.
- WAIT_RESP:
  - calc_cmd_out = 0, calc_data_out = 0.
  - On calc_resp_in != 0: capture calc_resp_in and calc_data_in -> RETURN.
  - Otherwise increment the counter; when it reaches TIMEOUT-1 with still no response, force resp = 3, data = 0 -> RETURN.
  - A response arriving on the same cycle as the timeout wins over the timeout.
- RETURN:
  - rsp_valid = 1 for 1 cycle with rsp_id = sel and the captured resp/data.
  - rr_ptr = (sel + 1) mod NUM_REQ -> IDLE.
  - A new grant is issued no earlier than the following IDLE cycle.
- Response codes: calc_resp_in = 3 from the calculator passes through unchanged; codes are not remapped.
- Latency: ready to first calculator command = 1 cycle. Minimum ready-to-rsp_valid = 4 cycles, with the calculator responding on the first WAIT_RESP cycle.
- Throughput: one operation in flight at a time; no queueing.
- Spurious calc_resp_in != 0 outside WAIT_RESP is ignored.
- req_valid dropping before grant: not granted; no state change.
- Reset mid-operation: the operation is dropped, no rsp_valid is produced, and calc_cmd_out returns to 0 immediately.
- Illegal command codes are forwarded unchanged; the calculator is expected to answer with resp 2.

Test Plan:
- Single op: req0 add op1 = 5, op2 = 7, calculator replies resp 1 / data 12 two cycles after SEND_OP2 -> calc_cmd_out shows 1 then 0; rsp_valid with rsp_id = 0, resp = 1, data = 12.
- Round-robin: req_valid = 4'b1111 held for 4 operations from reset -> grants in order 0, 1, 2, 3; then with req_valid = 4'b1010 -> grants 1, 3, 1.
- Error passthrough: sub op1 = 1, op2 = 2, calculator resp 2 -> rsp_resp = 2 delivered to the correct rsp_id.
- Timeout: the calculator never responds -> exactly TIMEOUT cycles in WAIT_RESP, then rsp_resp = 3, rsp_data = 0; the next requester is served afterwards.
- Tie: response arrives on the last timeout cycle with resp 1, data 9 -> rsp_resp = 1, rsp_data = 9.
- Reset during WAIT_RESP -> no rsp_valid; outputs 0 the same cycle; the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/calc_port_arbiter.sv
// calc_port_arbiter: round-robin share of one calculator port
// between NUM_REQ requesters, one operation in flight at a time.
module calc_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2,
  parameter int CMD_WIDTH  = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]  req_cmd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [RESP_WIDTH-1:0]         rsp_resp,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [CMD_WIDTH-1:0]          calc_cmd_out,
  output logic [DATA_WIDTH-1:0]         calc_data_out,
  input  logic [RESP_WIDTH-1:0]         calc_resp_in,
  input  logic [DATA_WIDTH-1:0]         calc_data_in,
  output logic                          busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] ID_LAST =
    ID_W'(NUM_REQ - 1);
  localparam logic [RESP_WIDTH-1:0] RESP_TMO =
    RESP_WIDTH'(3);

  typedef enum logic [2:0] {
    IDLE,
    SEND_OP1,
    SEND_OP2,
    WAIT_RESP,
    RETURN
  } state_t;

  state_t                 state;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        sel;
  logic [CMD_WIDTH-1:0]   cmd_q;
  logic [DATA_WIDTH-1:0]  op1_q;
  logic [DATA_WIDTH-1:0]  op2_q;
  logic [RESP_WIDTH-1:0]  resp_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [CNT_W-1:0]       cnt;

  logic                   pick_hit;
  logic [ID_W-1:0]        pick_idx;
  logic [NUM_REQ-1:0]     grant_vec;
  logic [CMD_WIDTH-1:0]   pick_cmd;
  logic [DATA_WIDTH-1:0]  pick_op1;
  logic [DATA_WIDTH-1:0]  pick_op2;

  // Round-robin search: walk from the highest offset down so the
  // requester closest to rr_ptr (offset 0) is the last to win.
  always_comb begin
    int               j;
    logic [ID_W-1:0]  idx;
    pick_hit = 1'b0;
    pick_idx = '0;
    j        = 0;
    idx      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      idx = j[ID_W-1:0];
      if (req_valid[idx]) begin
        pick_hit = 1'b1;
        pick_idx = idx;
      end
    end
  end

  // Payload mux and one-hot grant for the picked requester.
  always_comb begin
    grant_vec = '0;
    pick_cmd  = '0;
    pick_op1  = '0;
    pick_op2  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == pick_idx) begin
        grant_vec[i] = pick_hit;
        pick_cmd = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
        pick_op1 = req_op1[i*DATA_WIDTH +: DATA_WIDTH];
        pick_op2 = req_op2[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Operation sequencer; every output is a register that
  // reflects the decision taken on the previous edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      sel           <= '0;
      cmd_q         <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      resp_q        <= '0;
      data_q        <= '0;
      cnt           <= '0;
      req_ready     <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_resp      <= '0;
      rsp_data      <= '0;
      calc_cmd_out  <= '0;
      calc_data_out <= '0;
      busy          <= 1'b0;
    end else begin
      req_ready     <= '0;
      rsp_valid     <= 1'b0;
      calc_cmd_out  <= '0;
      calc_data_out <= '0;
      unique case (state)
        IDLE: begin
          if (pick_hit) begin
            req_ready <= grant_vec;
            sel       <= pick_idx;
            cmd_q     <= pick_cmd;
            op1_q     <= pick_op1;
            op2_q     <= pick_op2;
            state     <= SEND_OP1;
            busy      <= 1'b1;
          end
        end
        SEND_OP1: begin
          calc_cmd_out  <= cmd_q;
          calc_data_out <= op1_q;
          state         <= SEND_OP2;
        end
        SEND_OP2: begin
          calc_data_out <= op2_q;
          cnt           <= '0;
          state         <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (calc_resp_in != '0) begin
            resp_q <= calc_resp_in;
            data_q <= calc_data_in;
            state  <= RETURN;
          end else if (cnt == CNT_LAST) begin
            resp_q <= RESP_TMO;
            data_q <= '0;
            state  <= RETURN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RETURN: begin
          rsp_valid <= 1'b1;
          rsp_id    <= sel;
          rsp_resp  <= resp_q;
          rsp_data  <= data_q;
          if (sel == ID_LAST) begin
            rr_ptr <= '0;
          end else begin
            rr_ptr <= sel + 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_port_arbiter.sv
// tb_calc_port_arbiter: table-driven checks of grant order,
// calculator sequencing, timeout, tie and reset behaviour.
module tb_calc_port_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int RW  = 2;
  localparam int CW  = 4;
  localparam int TMO = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*CW-1:0]  req_cmd;
  logic [NR*DW-1:0]  req_op1;
  logic [NR*DW-1:0]  req_op2;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [RW-1:0]     rsp_resp;
  logic [DW-1:0]     rsp_data;
  logic [CW-1:0]     calc_cmd_out;
  logic [DW-1:0]     calc_data_out;
  logic [RW-1:0]     calc_resp_in;
  logic [DW-1:0]     calc_data_in;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  calc_port_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .RESP_WIDTH(RW),
    .CMD_WIDTH(CW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cmd(req_cmd),
    .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_resp(rsp_resp),
    .rsp_data(rsp_data), .calc_cmd_out(calc_cmd_out),
    .calc_data_out(calc_data_out),
    .calc_resp_in(calc_resp_in),
    .calc_data_in(calc_data_in), .busy(busy)
  );

  typedef struct {
    logic [NR-1:0] mask;
    logic [CW-1:0] cmd;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    int            d;
    logic [RW-1:0] cresp;
    logic [DW-1:0] cdata;
    int            id;
    logic [RW-1:0] eresp;
    logic [DW-1:0] edata;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(
    input logic [NR-1:0] mask, input logic [CW-1:0] cmd,
    input logic [DW-1:0] op1, input logic [DW-1:0] op2,
    input int d, input logic [RW-1:0] cresp,
    input logic [DW-1:0] cdata, input int id,
    input logic [RW-1:0] eresp, input logic [DW-1:0] edata);
    vec_t v;
    v.mask = mask; v.cmd = cmd; v.op1 = op1; v.op2 = op2;
    v.d = d; v.cresp = cresp; v.cdata = cdata; v.id = id;
    v.eresp = eresp; v.edata = edata;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Granted requester gets the vector payload; others get its
  // complement so a wrong mux select shows up on the port.
  task automatic drive_req(input vec_t v);
    for (int i = 0; i < NR; i++) begin
      if (i == v.id) begin
        req_cmd[i*CW +: CW] = v.cmd;
        req_op1[i*DW +: DW] = v.op1;
        req_op2[i*DW +: DW] = v.op2;
      end else begin
        req_cmd[i*CW +: CW] = ~v.cmd;
        req_op1[i*DW +: DW] = ~v.op1;
        req_op2[i*DW +: DW] = ~v.op2;
      end
    end
    req_valid = v.mask;
  endtask

  task automatic wait_grant(input vec_t v, output bit got);
    logic [NR-1:0] exp_rdy;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
    end
    chk("grant_seen", 64'(got), 64'd1);
    if (got) begin
      exp_rdy = '0;
      exp_rdy[v.id] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("busy_on_grant", 64'(busy), 64'd1);
    end
    req_valid = '0;
  endtask

  task automatic run_vec(input vec_t v);
    bit got;
    int lat;
    int exp_lat;
    drive_req(v);
    wait_grant(v, got);
    if (!got) return;
    @(negedge clk);
    chk("op1_cmd", 64'(calc_cmd_out), 64'(v.cmd));
    chk("op1_data", 64'(calc_data_out), 64'(v.op1));
    @(negedge clk);
    chk("op2_cmd", 64'(calc_cmd_out), 64'd0);
    chk("op2_data", 64'(calc_data_out), 64'(v.op2));
    lat = 2;
    got = 1'b0;
    while (lat < TMO + 20) begin
      if (lat - 2 == v.d) begin
        calc_resp_in = v.cresp;
        calc_data_in = v.cdata;
      end else begin
        calc_resp_in = '0;
        calc_data_in = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    calc_resp_in = '0;
    calc_data_in = '0;
    chk("rsp_seen", 64'(got), 64'd1);
    if (v.d >= 0 && v.d < TMO) exp_lat = 4 + v.d;
    else exp_lat = TMO + 3;
    chk("rsp_id", 64'(rsp_id), 64'(v.id));
    chk("rsp_resp", 64'(rsp_resp), 64'(v.eresp));
    chk("rsp_data", 64'(rsp_data), 64'(v.edata));
    chk("rsp_latency", 64'(lat), 64'(exp_lat));
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    vec_t fv;
    bit   got;
    int   seen;

    tbl[0]  = mk(4'b1111, 4'h1, 32'd10, 32'd20, 0,
                 2'd1, 32'd30, 0, 2'd1, 32'd30);
    tbl[1]  = mk(4'b1111, 4'h1, 32'd11, 32'd21, 1,
                 2'd1, 32'd32, 1, 2'd1, 32'd32);
    tbl[2]  = mk(4'b1111, 4'h2, 32'd12, 32'd22, 2,
                 2'd1, 32'hA, 2, 2'd1, 32'hA);
    tbl[3]  = mk(4'b1111, 4'h1, 32'd13, 32'd23, 0,
                 2'd1, 32'd36, 3, 2'd1, 32'd36);
    tbl[4]  = mk(4'b1010, 4'h1, 32'd1, 32'd1, 3,
                 2'd1, 32'd2, 1, 2'd1, 32'd2);
    tbl[5]  = mk(4'b1010, 4'h1, 32'd2, 32'd2, 0,
                 2'd1, 32'd4, 3, 2'd1, 32'd4);
    tbl[6]  = mk(4'b1010, 4'h1, 32'd3, 32'd3, 5,
                 2'd1, 32'd6, 1, 2'd1, 32'd6);
    tbl[7]  = mk(4'b0001, 4'h1, 32'd5, 32'd7, 1,
                 2'd1, 32'd12, 0, 2'd1, 32'd12);
    tbl[8]  = mk(4'b0100, 4'h2, 32'd1, 32'd2, 1,
                 2'd2, 32'hFFFF_FFFF, 2, 2'd2, 32'hFFFF_FFFF);
    tbl[9]  = mk(4'b1001, 4'h3, 32'h40, 32'h15, 0,
                 2'd3, 32'h55, 3, 2'd3, 32'h55);
    tbl[10] = mk(4'b0010, 4'h1, 32'h99, 32'h1, -1,
                 2'd0, 32'd0, 1, 2'd3, 32'd0);
    tbl[11] = mk(4'b1111, 4'h1, 32'd4, 32'd4, 0,
                 2'd1, 32'd8, 2, 2'd1, 32'd8);
    tbl[12] = mk(4'b0001, 4'h1, 32'd4, 32'd5, TMO - 1,
                 2'd1, 32'd9, 0, 2'd1, 32'd9);
    tbl[13] = mk(4'b1100, 4'hF, 32'h7, 32'h8, 2,
                 2'd2, 32'd0, 2, 2'd2, 32'd0);

    rst          = 1'b1;
    req_valid    = '0;
    req_cmd      = '0;
    req_op1      = '0;
    req_op2      = '0;
    calc_resp_in = '0;
    calc_data_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_cmd", 64'(calc_cmd_out), 64'd0);
    chk("rst_data", 64'(calc_data_out), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_vec(tbl[i]);
    end

    // Spurious responses while idle must be ignored.
    calc_resp_in = 2'd1;
    calc_data_in = 32'h77;
    @(negedge clk);
    chk("rsp_single_pulse", 64'(rsp_valid), 64'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    chk("spurious_ignored", 64'(seen), 64'd0);
    calc_resp_in = '0;
    calc_data_in = '0;

    // Reset while waiting for the calculator.
    rv = mk(4'b0100, 4'h1, 32'h1111, 32'h1234, -1,
            2'd0, 32'd0, 2, 2'd0, 32'd0);
    drive_req(rv);
    wait_grant(rv, got);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_op2", 64'(calc_data_out), 64'h1234);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_data", 64'(calc_data_out), 64'd0);
    chk("midrst_cmd", 64'(calc_cmd_out), 64'd0);
    calc_resp_in = 2'd1;
    @(negedge clk);
    @(negedge clk);
    calc_resp_in = '0;
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_rst", 64'(seen), 64'd0);

    fv = mk(4'b1111, 4'h1, 32'h20, 32'h30, 0,
            2'd1, 32'hABCD, 0, 2'd1, 32'hABCD);
    run_vec(fv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
